bcd_seg_scan: RTL and testbench
===============================

# bcd_seg_scan

Display-side consumer of the 16-bit packed BCD word from the binary-to-BCD converter. It latches a new four-digit BCD value on a valid strobe and time-multiplexes it onto a common-segment 7-segment display, one digit per scan slot. New values are double-buffered so they only take effect at a frame boundary, which prevents tearing mid-scan. Sits between the BCD converter and the board display pins.

## Interface
- CLK_DIV, 50000, clock cycles per digit slot; legal range ≥1
- SEG_ACTIVE_LOW, 1, 1: seg and dig_sel drive 0 for on; 0: drive 1 for on
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bcd_in  input  16  packed BCD; [3:0] is digit 0 (least significant), [15:12] is digit 3
- bcd_valid  input  1  single-cycle strobe; bcd_in is valid in this cycle
- dp_in  input  4  decimal point per digit, sampled together with bcd_in
- seg  output  8  [7]=dp, [6:0]=g..a
- dig_sel  output  4  one-hot digit enable; bit k drives digit k
- frame_done  output  1  one-cycle pulse at each frame wrap

One clock; reset is asynchronous and active-high.

## Operation
- **Prescaler** counts 0..CLK_DIV-1 and wraps. `tick` asserts when the count equals CLK_DIV-1.
- **Digit index** is 2 bits and advances 0→1→2→3→0 on each tick. `wrap` = tick while index==3.
- **Pending buffer:**
  - bcd_valid loads bcd_in and dp_in into pending and sets pend_flag.
  - Several strobes within one frame: the last one wins.
- **Active buffer:** on wrap with pend_flag set, pending is copied to active and pend_flag is cleared.
  - If bcd_valid coincides with wrap, active loads bcd_in/dp_in directly and pend_flag ends cleared.
- **Decode** (by sub-module) of the nibble selected by the next index:
  - 0–9: standard glyph.
  - 0xA–0xF: dash (segment g only).
- dp follows the dp bit of the active digit. dp is not affected by blanking.
- Polarity inversion is applied at the output register when SEG_ACTIVE_LOW=1.

## Timing
- **Reset values:**
  - prescaler=0, index=0, pending=0, active=0, pend_flag=0, frame_done=0.
  - seg and dig_sel are all-inactive: 8'hFF / 4'hF when active-low, 0 otherwise.
- seg, dig_sel and frame_done are registered. They update on the clock edge after the tick cycle.
- Outputs stay all-inactive until the first tick, at cycle CLK_DIV-1 after reset release. Digit 0 lights on the following edge.
- Each digit is lit for exactly CLK_DIV cycles. A frame is 4·CLK_DIV cycles.
- frame_done pulses for one cycle, registered from wrap, aligned with digit 0 becoming lit.
- **Latency** from bcd_valid to the new value on digit 0: at most 4·CLK_DIV+1 cycles, at least 1 cycle (strobe on wrap).
- **CLK_DIV=1:** tick every cycle, and the digit changes every cycle.
- **Reset mid-frame:** everything returns to reset values immediately (asynchronous). Any pending value is discarded.

## Configuration
- **LEADING_ZERO_BLANK_EN**
  - Defined: any digit above the most significant nonzero digit has segments a–g forced inactive, with dig_sel still cycling. Digit 0 is never blanked, so a value of 0 shows a single "0". A nibble ≥0xA counts as nonzero.
  - Undefined: all four digits are always displayed, including leading zeros.

## Structure
- **Shared package:**
  - Segment glyph constants for 0–9, dash and blank (active-high a..g encoding).
  - Digit count constant 4.
  - The 2-bit digit index type.
- **Sub-module `bcd7seg_decode`:** purely combinational. Takes a 4-bit nibble and produces an active-high 7-bit glyph. Instantiated once, on the muxed nibble.
- Top level holds the prescaler, index, pending/active buffers, blanking logic and output registers.

## Test plan
All scenarios use CLK_DIV=4 and SEG_ACTIVE_LOW=1.
1. **Reset:** hold rst, release → seg=8'hFF, dig_sel=4'hF for 4 cycles; then dig_sel=4'b1110 showing "0" (seg=8'hC0).
2. **Update:** bcd_valid with bcd_in=16'h1234, dp_in=0 mid-frame → no change until frame_done. Then digits 0..3 show seg=8'h99, 8'hB0, 8'hA4, 8'hF9, each for 4 cycles.
3. **Blanking** (macro on): bcd_in=16'h0070 → digit0 seg=8'hC0, digit1 8'hF8, digits 2–3 8'hFF while their dig_sel is active. With the macro off, digits 2–3 show 8'hC0.
4. **Invalid nibble and dp:** bcd_in=16'h000A, dp_in=4'b0001 → digit 0 seg=8'h3F (dash plus dp on).
5. **Strobe collisions:**
   - Strobes of 16'h1111 then 16'h2222 within one frame → only 2222 is displayed.
   - A strobe in the exact wrap cycle → value is shown on the immediately following digit 0.
6. **Reset mid-frame** with a pending value → outputs go inactive asynchronously. After release, "0" is displayed and the pending value is never shown.

Source files
------------

// File: rtl/bcd_seg_scan_pkg.sv
// Shared definitions for the BCD 7-segment scanner: glyphs (active-high, bit order g..a),
// digit count and the digit index type.
package bcd_seg_scan_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/bcd_seg_scan_decode.sv
// Combinational BCD nibble to active-high 7-segment glyph; non-BCD nibbles show a dash.
module bcd7seg_decode
    import bcd_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DASH;
        case (nibble)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seg_scan
    import bcd_seg_scan_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    input  logic [3:0]  dp_in,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel,
    output logic        frame_done
);

    localparam int              PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]      SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]      DIG_OFF = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PW-1:0]  ps_cnt;
    digit_idx_t     idx;
    logic           tick;
    logic           wrap;
    logic [15:0]    pend_bcd, act_bcd, nxt_bcd;
    logic [3:0]     pend_dp, act_dp, nxt_dp;
    logic           pend_flag;
    logic [3:0]     nib;
    logic [6:0]     glyph;
    logic           blank;
    logic [7:0]     seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    // idx is the digit lit by the next tick, so the tick that lights digit 0 is the frame wrap.
    assign tick = (ps_cnt == PS_LAST);
    assign wrap = tick && (idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt <= '0;
            idx    <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
            idx    <= idx + 1'b1;
        end else begin
            ps_cnt <= ps_cnt + PW'(1);
        end
    end

    // A strobe landing on the wrap bypasses pending and is displayed on this very edge.
    always_comb begin
        nxt_bcd = act_bcd;
        nxt_dp  = act_dp;
        if (wrap) begin
            if (bcd_valid) begin
                nxt_bcd = bcd_in;
                nxt_dp  = dp_in;
            end else if (pend_flag) begin
                nxt_bcd = pend_bcd;
                nxt_dp  = pend_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bcd  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_bcd   <= '0;
            act_dp    <= '0;
        end else begin
            act_bcd <= nxt_bcd;
            act_dp  <= nxt_dp;
            if (bcd_valid) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
            end
            if (bcd_valid && !wrap)
                pend_flag <= 1'b1;
            else if (wrap)
                pend_flag <= 1'b0;
        end
    end

    assign nib = nxt_bcd[{idx, 2'b00} +: 4];

    bcd7seg_decode u_decode (
        .nibble (nib),
        .glyph  (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (nxt_bcd[15:4]  == '0);
            2'd2:    blank = (nxt_bcd[15:8]  == '0);
            2'd3:    blank = (nxt_bcd[15:12] == '0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_raw = {nxt_dp[idx], blank ? GLYPH_BLANK : glyph};
    assign dig_raw = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                seg     <= seg_raw ^ SEG_OFF;
                dig_sel <= dig_raw ^ DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (CLK_DIV=4, active-low); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_seg_scan;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_done;

    bcd_seg_scan #(.CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .dp_in      (dp_in),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        int         k;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_val, pend_val;
    logic [3:0]  model_dp, pend_dp;
    bit          model_pend;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Active-low seg byte expected for digit k of value v.
    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp, input int k);
        logic [7:0] lut [10];
        logic [3:0] n;
        logic [7:0] s;
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        n = v[4*k +: 4];
        s = (n <= 4'd9) ? lut[n] : 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
        if (k != 0 && (v >> (4*k)) == 16'h0) s = 8'hFF;
`endif
        if (dp[k]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.seg = exp_seg(v, dp, k);
            e.dig = ~(4'b0001 << k);
            e.k   = k;
            sb_q.push_back(e);
        end
    endtask

    task automatic frame_start();
        if (model_pend) begin
            model_val  = pend_val;
            model_dp   = pend_dp;
            model_pend = 1'b0;
        end
        if (sb_q.size() == 0) push_frame(model_val, model_dp);
    endtask

    // Checks one digit slot (CLK_DIV cycles) starting at a negedge; optionally strobes at cycle sc.
    task automatic check_digit(input bit do_strobe, input int sc, input logic [15:0] nv, input logic [3:0] ndp);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int c = 0; c < CLK_DIV; c++) begin
            bcd_valid = do_strobe && (c == sc);
            if (bcd_valid) begin
                bcd_in = nv;
                dp_in  = ndp;
                if (model_pend) repeat (4) void'(sb_q.pop_back());
                push_frame(nv, ndp);
                pend_val   = nv;
                pend_dp    = ndp;
                model_pend = 1'b1;
            end
            check_eq($sformatf("seg d%0d c%0d", e.k, c), seg, e.seg);
            check_eq($sformatf("dig_sel d%0d c%0d", e.k, c), dig_sel, e.dig);
            check_eq($sformatf("frame_done d%0d c%0d", e.k, c), frame_done, (c == 0 && e.k == 0));
            @(negedge clk);
        end
        bcd_valid = 1'b0;
    endtask

    task automatic plain_frame();
        frame_start();
        for (int k = 0; k < 4; k++) check_digit(1'b0, 0, 16'h0, 4'h0);
    endtask

    task automatic strobe_frame(input int slot, input int sc, input logic [15:0] nv, input logic [3:0] ndp);
        frame_start();
        for (int k = 0; k < 4; k++) check_digit(k == slot, sc, nv, ndp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_val  = '0;
        model_dp   = '0;
        model_pend = 1'b0;
        sb_q.delete();
        for (int c = 0; c < CLK_DIV; c++) begin
            check_eq("rst seg", seg, 8'hFF);
            check_eq("rst dig_sel", dig_sel, 4'hF);
            check_eq("rst frame_done", frame_done, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset, then first frame shows a single 0
        do_reset();
        plain_frame();

        // Mid-frame update only appears at the next frame
        strobe_frame(1, 2, 16'h1234, 4'h0);
        plain_frame();

        // Leading zeros (blanked only when the macro is defined)
        strobe_frame(0, 1, 16'h0070, 4'h0);
        plain_frame();

        // Non-BCD nibble shows dash, with decimal point
        strobe_frame(2, 0, 16'h000A, 4'b0001);
        plain_frame();

        // Two strobes in one frame: the last wins
        frame_start();
        check_digit(1'b1, 1, 16'h1111, 4'h0);
        check_digit(1'b1, 1, 16'h2222, 4'h0);
        check_digit(1'b0, 0, 16'h0, 4'h0);
        check_digit(1'b0, 0, 16'h0, 4'h0);
        plain_frame();

        // Strobe on the wrap cycle is shown on the very next digit 0
        strobe_frame(3, CLK_DIV - 1, 16'h9876, 4'b1010);
        plain_frame();

        // Asynchronous reset mid-frame discards a pending value
        frame_start();
        check_digit(1'b0, 0, 16'h0, 4'h0);
        check_digit(1'b1, 1, 16'h5678, 4'h0);
        check_digit(1'b0, 0, 16'h0, 4'h0);
        #1 rst = 1'b1;
        #1;
        check_eq("async rst seg", seg, 8'hFF);
        check_eq("async rst dig_sel", dig_sel, 4'hF);
        check_eq("async rst frame_done", frame_done, 1'b0);
        @(negedge clk);
        do_reset();
        plain_frame();
        plain_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
